// File: rtl/avgpool_sched_pkg.sv
// Shared types, defaults and sizing helpers for the avgpool frame scheduler.
package avgpool_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_IMG_WIDTH  = 32;
  localparam int unsigned DEF_IMG_HEIGHT = 32;
  localparam int unsigned DEF_IN_WIDTH   = 4;
  localparam int unsigned DEF_OUT_WIDTH  = 6;

  function automatic int unsigned pix_per_frame(int unsigned w, int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned res_per_frame(int unsigned w, int unsigned h);
    return (w / 2) * (h / 2);
  endfunction

  function automatic int unsigned ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avgpool_sched_if.sv
// Channel, engine and result-side signals of the frame scheduler.
interface avgpool_sched_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 6
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*IN_WIDTH-1:0] ch_din;
  logic [NUM_CH-1:0]          ch_valid;
  logic [NUM_CH-1:0]          ch_ready;
  logic [IN_WIDTH-1:0]        eng_din;
  logic                       eng_din_valid;
  logic                       eng_din_ready;
  logic [OUT_WIDTH-1:0]       eng_dout;
  logic                       eng_dout_valid;
  logic                       eng_dout_ready;
  logic [OUT_WIDTH-1:0]       out_data;
  logic [CH_W-1:0]            out_ch;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
  logic                       frame_done;

  modport master (
    input  ch_din, ch_valid, eng_din_ready, eng_dout, eng_dout_valid, out_ready,
    output ch_ready, eng_din, eng_din_valid, eng_dout_ready,
           out_data, out_ch, out_last, out_valid, busy, frame_done
  );

  modport slave (
    output ch_din, ch_valid, eng_din_ready, eng_dout, eng_dout_valid, out_ready,
    input  ch_ready, eng_din, eng_din_valid, eng_dout_ready,
           out_data, out_ch, out_last, out_valid, busy, frame_done
  );
endinterface

// File: rtl/avgpool_sched_skid.sv
// Two-entry FIFO holding tagged pool results between engine and downstream.
module pool_out_skid #(
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [CH_W-1:0]   push_ch_i,
  input  logic              push_last_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        cnt_o,
  output logic [CH_W-1:0]   head_ch_o,
  output logic              head_last_o,
  output logic [DATA_W-1:0] head_data_o
);
  localparam int unsigned ENT_W = CH_W + 1 + DATA_W;

  logic [ENT_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy; push and pop in the same cycle keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {push_ch_i, push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign cnt_o = cnt_q;
  assign {head_ch_o, head_last_o, head_data_o} = mem_q[rd_ptr_q];
endmodule

// File: rtl/avgpool_frame_scheduler.sv
// Frame-granular round-robin sharing of one avgpool engine among NUM_CH streams.
module avgpool_frame_scheduler
  import avgpool_sched_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  avgpool_sched_if.master bus
);
  localparam int unsigned CH_W          = ch_w(NUM_CH);
  localparam int unsigned PIX_PER_FRAME = pix_per_frame(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned RES_PER_FRAME = res_per_frame(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned PIX_W         = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
  localparam int unsigned RES_W         = $clog2(RES_PER_FRAME + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [RES_W-1:0]  res_cnt_q, res_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic [CH_W-1:0]   pick;
  logic              any_req;
  int unsigned       slot;
  logic              pix_hs;
  logic              push;
  logic              pop;
  logic [1:0]        skid_cnt;
  logic [CH_W-1:0]   head_ch;
  logic              head_last;
  logic [OUT_WIDTH-1:0] head_data;

  // First requesting channel at or after rr_q, wrapping.
  always_comb begin
    pick    = rr_q;
    any_req = 1'b0;
    slot    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot = int'(rr_q) + i;
      if (slot >= NUM_CH) slot = slot - NUM_CH;
      if (!any_req && bus.ch_valid[CH_W'(slot)]) begin
        any_req = 1'b1;
        pick    = CH_W'(slot);
      end
    end
  end

  // Pixel mux towards the engine; only the granted channel sees ready.
  always_comb begin
    bus.eng_din       = '0;
    bus.eng_din_valid = 1'b0;
    bus.ch_ready      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (state_q == STREAM && grant_q == CH_W'(i)) begin
        bus.eng_din       = bus.ch_din[i*IN_WIDTH +: IN_WIDTH];
        bus.eng_din_valid = bus.ch_valid[i];
        bus.ch_ready[i]   = bus.eng_din_ready;
      end
    end
    bus.eng_dout_ready = (skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && bus.out_ready);
  end

  assign pix_hs = (state_q == STREAM) && bus.eng_din_valid && bus.eng_din_ready;
  assign push   = bus.eng_dout_valid;
  assign pop    = bus.out_valid && bus.out_ready;

  // Next-state, grant, round-robin pointer and frame counters.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    pix_cnt_d    = pix_cnt_q;
    res_cnt_d    = push ? res_cnt_q + RES_W'(1) : res_cnt_q;
    frame_done_d = pop && head_last;
    case (state_q)
      IDLE: begin
        res_cnt_d = '0;
        pix_cnt_d = '0;
        if (any_req) begin
          grant_d = pick;
          rr_d    = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pix_hs) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(PIX_PER_FRAME - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_cnt_q == RES_W'(RES_PER_FRAME) && skid_cnt == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      pix_cnt_q    <= '0;
      res_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      pix_cnt_q    <= pix_cnt_d;
      res_cnt_q    <= res_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  pool_out_skid #(
    .CH_W   (CH_W),
    .DATA_W (OUT_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_ch_i   (grant_q),
    .push_last_i (res_cnt_q == RES_W'(RES_PER_FRAME - 1)),
    .push_data_i (bus.eng_dout),
    .pop_i       (pop),
    .cnt_o       (skid_cnt),
    .head_ch_o   (head_ch),
    .head_last_o (head_last),
    .head_data_o (head_data)
  );

  assign bus.out_valid  = (skid_cnt != 2'd0);
  assign bus.out_data   = head_data;
  assign bus.out_ch     = head_ch;
  assign bus.out_last   = head_last;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_avgpool_frame_scheduler.sv
// Scoreboard bench for avgpool_frame_scheduler with a behavioural 2x2 sum engine.
module tb_avgpool_frame_scheduler;
  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int H   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avgpool_sched_if #(.NUM_CH(4), .IN_WIDTH(4), .OUT_WIDTH(6)) bus ();

  avgpool_frame_scheduler #(
    .NUM_CH(4), .IMG_WIDTH(W), .IMG_HEIGHT(H), .IN_WIDTH(4), .OUT_WIDTH(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic       last;
    logic [5:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  int   frames_exp = 0;
  int   viol = 0;
  bit   last_pop = 1'b0;
  bit   seen_low;

  logic       tb_valid [NCH];
  logic [3:0] tb_din   [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      bus.ch_valid[i]       = tb_valid[i];
      bus.ch_din[i*4 +: 4]  = tb_din[i];
    end
  end

  // Engine stand-in: accepts whenever it can emit, sums each 2x2 block, pulses one cycle after.
  assign bus.eng_din_ready = bus.eng_dout_ready;
  int         e_idx;
  int         e_r, e_c;
  logic [5:0] acc [2];
  always_comb begin
    e_r = e_idx / W;
    e_c = e_idx % W;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_idx              <= 0;
      bus.eng_dout_valid <= 1'b0;
      bus.eng_dout       <= '0;
      acc[0]             <= '0;
      acc[1]             <= '0;
    end else begin
      bus.eng_dout_valid <= 1'b0;
      if (bus.eng_din_valid && bus.eng_din_ready) begin
        if (e_r % 2 == 0 && e_c % 2 == 0)
          acc[e_c/2] <= 6'(bus.eng_din);
        else if (e_r % 2 == 1 && e_c % 2 == 1) begin
          bus.eng_dout       <= acc[e_c/2] + 6'(bus.eng_din);
          bus.eng_dout_valid <= 1'b1;
        end else
          acc[e_c/2] <= acc[e_c/2] + 6'(bus.eng_din);
        e_idx <= (e_idx == W*H-1) ? 0 : e_idx + 1;
      end
    end
  end

  task automatic expect_frame(input logic [1:0] ch, input logic [5:0] s0, input logic [5:0] s1);
    exp_q.push_back({ch, 1'b0, s0});
    exp_q.push_back({ch, 1'b1, s1});
    frames_exp++;
  endtask

  task automatic wait_rdy(input int ch);
    bit got = 1'b0;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      got = bus.ch_ready[ch];
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ch_ready_timeout ch=%0d got=0 want=1", ch);
    end
    @(posedge clk); #1;
  endtask

  // Sends n pixels (nibble k of px is pixel k), optionally dropping valid for gap cycles between them.
  task automatic send_pix(input int ch, input logic [31:0] px, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      tb_din[ch]   = px[k*4 +: 4];
      tb_valid[ch] = 1'b1;
      wait_rdy(ch);
      if (gap > 0 && k < n-1) begin
        tb_valid[ch] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    tb_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.busy;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s drain_timeout pending=%0d busy=%0b want pending=0 busy=0",
               name, exp_q.size(), bus.busy);
    end
  endtask

  task automatic check_zero(input string name);
    logic [20:0] v;
    v = {bus.ch_ready, bus.eng_din, bus.eng_din_valid, bus.out_data, bus.out_ch,
         bus.out_last, bus.out_valid, bus.busy, bus.frame_done};
    n_vec++;
    if (v !== '0) begin
      n_err++;
      $display("FAIL %s outputs=%h want=0", name, v);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted result and checks frame_done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pop = 1'b0;
      end else begin
        if (!$onehot0(bus.ch_ready) || (bus.ch_ready != 0 && !bus.busy)) viol++;
        if (bus.frame_done || last_pop) begin
          n_vec++;
          if (bus.frame_done !== last_pop) begin
            n_err++;
            $display("FAIL frame_done got=%0b want=%0b", bus.frame_done, last_pop);
          end
          if (bus.frame_done) fd_cnt++;
        end
        last_pop = bus.out_valid && bus.out_ready && bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL result_unexpected got ch=%0d last=%0b data=%0d want none",
                     bus.out_ch, bus.out_last, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_last, bus.out_data} !== e) begin
              n_err++;
              $display("FAIL result got ch=%0d last=%0b data=%0d want ch=%0d last=%0b data=%0d",
                       bus.out_ch, bus.out_last, bus.out_data, e.ch, e.last, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      tb_valid[i] = 1'b0;
      tb_din[i]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ch1, all pixels 3.
    expect_frame(2'd1, 6'd12, 6'd12);
    send_pix(1, 32'h3333_3333, 8, 0);
    wait_idle("ch1_const");

    // ch3, all pixels 15: maximum sum.
    expect_frame(2'd3, 6'd60, 6'd60);
    send_pix(3, 32'hFFFF_FFFF, 8, 0);
    wait_idle("ch3_max");

    // ch2 pixels 1..8 with valid gaps, then the same frame gap-free.
    expect_frame(2'd2, 6'd14, 6'd22);
    send_pix(2, 32'h8765_4321, 8, 2);
    wait_idle("ch2_gaps");
    expect_frame(2'd2, 6'd14, 6'd22);
    send_pix(2, 32'h8765_4321, 8, 0);
    wait_idle("ch2_nogaps");

    // Downstream stall for 10 cycles across two back-to-back frames.
    expect_frame(2'd1, 6'd14, 6'd22);
    expect_frame(2'd1, 6'd12, 6'd12);
    seen_low = 1'b0;
    fork
      begin
        send_pix(1, 32'h8765_4321, 8, 0);
        send_pix(1, 32'h3333_3333, 8, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (!bus.eng_dout_ready) seen_low = 1'b1;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_idle("backpressure");
    n_vec++;
    if (seen_low !== 1'b1) begin
      n_err++;
      $display("FAIL stall_eng_dout_ready_low got=%0b want=1", seen_low);
    end

    // Reset after five pixels of a ch3 frame.
    send_pix(3, 32'h9999_9999, 5, 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_frame");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ch0 and ch2 competing: frames ch0, ch2, ch0.
    expect_frame(2'd0, 6'd14, 6'd22);
    expect_frame(2'd2, 6'd8, 6'd8);
    expect_frame(2'd0, 6'd20, 6'd20);
    fork
      begin
        send_pix(0, 32'h8765_4321, 8, 0);
        send_pix(0, 32'h5555_5555, 8, 0);
      end
      send_pix(2, 32'h2222_2222, 8, 0);
    join
    wait_idle("round_robin");

    n_vec++;
    if (viol != 0) begin
      n_err++;
      $display("FAIL ch_ready_exclusive violations got=%0d want=0", viol);
    end
    n_vec++;
    if (fd_cnt != frames_exp) begin
      n_err++;
      $display("FAIL frame_done_count got=%0d want=%0d", fd_cnt, frames_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
